// File: rtl/usb_tx_packet_scheduler.sv
// usb_tx_packet_scheduler
// Arbitrates the USB transmit path between a handshake responder and a data-packet
// source. It loads the PID byte and the payload into the TX FIFO, pulses tx_start,
// follows tx_busy until the packet is on the wire, then grants the requester.
// It also tracks the DATA0/DATA1 toggle.
// Optional build macro: USB_TX_TIMEOUT_EN. When it is defined, a watchdog bounds the
// transmitter wait states.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no packet; arbitrate hs_req (priority) over data_req
// WR_PID      | write the PID byte once the FIFO has room
// RD          | present the payload byte index on buf_raddr
// WR          | write buf_rdata to the FIFO once it has room, then advance the index
// START       | one-cycle tx_start pulse
// WAIT_BSY    | wait for the transmitter to go busy
// WAIT_DONE   | wait for the transmitter to go idle
// GRANT       | one-cycle grant pulse to the owner
module usb_tx_packet_scheduler #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             hs_req,
    input  logic [1:0]       hs_pid,
    output logic             hs_gnt,
    input  logic             data_req,
    input  logic [LEN_W-1:0] data_len,
    output logic             data_gnt,
    output logic [LEN_W-1:0] buf_raddr,
    input  logic [7:0]       buf_rdata,
    input  logic             fifo_full,
    output logic             fifo_wen,
    output logic [7:0]       fifo_wdata,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic             ack_rcvd,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_PID, S_RD, S_WR, S_START, S_WAIT_BSY, S_WAIT_DONE, S_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic             owner_data_q;
    logic [1:0]       pid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic             toggle_q;
    logic [LEN_W-1:0] len_clamped;
    logic [7:0]       pid_byte;
    logic             last_byte;
    logic             timed_out;

    assign len_clamped = (data_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : data_len;
    assign last_byte   = ((idx_q + LEN_W'(1)) == len_q);
    assign buf_raddr   = idx_q;
    assign busy        = (state_q != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Latch the owner, PID and clamped length when a request is accepted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            owner_data_q <= 1'b0;
            pid_q        <= 2'b00;
            len_q        <= '0;
        end else if (state_q == S_IDLE && (hs_req || data_req)) begin
            owner_data_q <= !hs_req;
            pid_q        <= hs_pid;
            len_q        <= len_clamped;
        end
    end

    // Payload byte index. It advances only on an actual FIFO write, so a stall neither drops nor repeats a byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                              idx_q <= '0;
        else if (state_q == S_IDLE)              idx_q <= '0;
        else if (state_q == S_WR && !fifo_full)  idx_q <= idx_q + LEN_W'(1);
    end

    // Data toggle flips on every host ACK. A flip during the PID write affects only the next packet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        toggle_q <= 1'b0;
        else if (ack_rcvd) toggle_q <= ~toggle_q;
    end

`ifdef USB_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT));

    // Wait-cycle counter. It runs only while waiting on the transmitter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            wait_cnt_q <= '0;
        else if ((state_q == S_WAIT_BSY || state_q == S_WAIT_DONE) && !timed_out)
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        else
            wait_cnt_q <= '0;
    end
`else
    assign timed_out = 1'b0;
`endif

    // PID byte for the latched owner
    always_comb begin
        pid_byte = 8'h1E;
        if (owner_data_q) begin
            pid_byte = toggle_q ? 8'h4B : 8'hC3;
        end else begin
            case (pid_q)
                2'b00:   pid_byte = 8'hD2;
                2'b01:   pid_byte = 8'h5A;
                default: pid_byte = 8'h1E;
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        fifo_wen    = 1'b0;
        fifo_wdata  = 8'h00;
        tx_start    = 1'b0;
        hs_gnt      = 1'b0;
        data_gnt    = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs_req || data_req) state_d = S_WR_PID;
            end
            S_WR_PID: begin
                if (!fifo_full) begin
                    fifo_wen   = 1'b1;
                    fifo_wdata = pid_byte;
                    state_d    = (owner_data_q && len_q != '0) ? S_RD : S_START;
                end
            end
            S_RD: state_d = S_WR;
            S_WR: begin
                if (!fifo_full) begin
                    fifo_wen   = 1'b1;
                    fifo_wdata = buf_rdata;
                    state_d    = last_byte ? S_START : S_RD;
                end
            end
            S_START: begin
                tx_start = 1'b1;
                state_d  = S_WAIT_BSY;
            end
            S_WAIT_BSY: begin
                if (timed_out) begin
                    timeout_err = 1'b1;
                    state_d     = S_GRANT;
                end else if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (timed_out) begin
                    timeout_err = 1'b1;
                    state_d     = S_GRANT;
                end else if (!tx_busy) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                hs_gnt   = !owner_data_q;
                data_gnt = owner_data_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_packet_scheduler.sv
// Testbench for usb_tx_packet_scheduler.
// Each write to the FIFO is scored against a queue of expected bytes and addresses.
// The bench fills that queue when it issues each request.
// The transmitter model raises tx_busy two cycles after tx_start and holds it for busy_len cycles.
module tb_usb_tx_packet_scheduler;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam int TIMEOUT = 1023;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             hs_req, data_req, fifo_full, ack_rcvd;
    logic [1:0]       hs_pid;
    logic [LEN_W-1:0] data_len;
    logic             hs_gnt, data_gnt, fifo_wen, tx_start, busy, timeout_err;
    logic [LEN_W-1:0] buf_raddr;
    logic [7:0]       buf_rdata, fifo_wdata;
    logic             tx_busy;

    typedef struct {
        logic [7:0] data;
        int         addr;
        bit         payload;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         tog = 1'b0;
    int         busy_len = 10;
    int         wr_count = 0;
    int         hs_gnt_cnt = 0;
    int         data_gnt_cnt = 0;
    logic [7:0] buf_mem [0:127];
    logic       start_d;
    int         busy_cnt;

    usb_tx_packet_scheduler #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
        .data_req(data_req), .data_len(data_len), .data_gnt(data_gnt),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .fifo_full(fifo_full),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .tx_start(tx_start),
        .tx_busy(tx_busy), .ack_rcvd(ack_rcvd), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Payload buffer with one cycle of read latency
    always @(posedge clk) buf_rdata <= buf_mem[buf_raddr];

    // Transmitter model
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            start_d  <= 1'b0;
            busy_cnt <= 0;
        end else begin
            start_d <= tx_start;
            if (start_d)           busy_cnt <= busy_len;
            else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt > 0);

    // Scoreboard and protocol monitor
    always @(negedge clk) begin
        if (n_rst) begin
            if (hs_gnt)   hs_gnt_cnt++;
            if (data_gnt) data_gnt_cnt++;
            if (tx_start) begin
                n_checks++;
                if (tx_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_while_busy: tx_busy=%b required 0", tx_busy);
                end
            end
            if (fifo_wen) begin
                wr_count++;
                n_checks++;
                if (fifo_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wen_while_full: fifo_full=%b required 0", fifo_full);
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h required no write", fifo_wdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_checks++;
                    if (fifo_wdata !== e.data) begin
                        n_fail++;
                        $display("FAIL write_byte: got %h required %h", fifo_wdata, e.data);
                    end
                    if (e.payload) begin
                        n_checks++;
                        if (buf_raddr !== LEN_W'(e.addr)) begin
                            n_fail++;
                            $display("FAIL write_raddr: got %0d required %0d", buf_raddr, e.addr);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [7:0] hs_byte(input logic [1:0] p);
        case (p)
            2'b00:   return 8'hD2;
            2'b01:   return 8'h5A;
            default: return 8'h1E;
        endcase
    endfunction

    task automatic push_expect(input bit is_data, input logic [1:0] pid, input int len);
        exp_t e;
        int   n;
        e.addr    = 0;
        e.payload = 1'b0;
        e.data    = is_data ? (tog ? 8'h4B : 8'hC3) : hs_byte(pid);
        exp_q.push_back(e);
        if (is_data) begin
            n = (len > MAX_LEN) ? MAX_LEN : len;
            for (int i = 0; i < n; i++) begin
                e.data    = buf_mem[i];
                e.addr    = i;
                e.payload = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_ack();
        ack_rcvd = 1'b1;
        @(posedge clk); #1;
        ack_rcvd = 1'b0;
        tog = ~tog;
    endtask

    // Issue one request and hold it until its grant. Cycles are counted from the request to tx_start and from tx_start to the grant.
    task automatic run_packet(input bit is_data, input logic [1:0] pid, input int len,
                              input bit ack_in_pid, output int t_start, output int t_gnt);
        int n;
        push_expect(is_data, pid, len);
        t_start = -1;
        t_gnt   = -1;
        if (is_data) begin
            data_len = LEN_W'(len);
            data_req = 1'b1;
        end else begin
            hs_pid = pid;
            hs_req = 1'b1;
        end
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) ack_rcvd = 1'b0;
            if (n == 1 && ack_in_pid) begin
                ack_rcvd = 1'b1;
                tog = ~tog;
            end
            if (tx_start) begin
                t_start = n;
                break;
            end
        end
        ack_rcvd = 1'b0;
        n = 0;
        while (t_start >= 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if ((is_data ? data_gnt : hs_gnt) === 1'b1) begin
                t_gnt = n;
                break;
            end
        end
        hs_req   = 1'b0;
        data_req = 1'b0;
        if (t_start < 0 || t_gnt < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_bound: t_start=%0d t_gnt=%0d required both seen", t_start, t_gnt);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        hs_req = 0; data_req = 0; fifo_full = 0; ack_rcvd = 0; hs_pid = 0; data_len = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({hs_gnt, data_gnt, fifo_wen, tx_start, busy, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 000000",
                     {hs_gnt, data_gnt, fifo_wen, tx_start, busy, timeout_err});
        end
        n_checks++;
        if (buf_raddr !== '0 || fifo_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_buses: raddr=%0d wdata=%h required 0", buf_raddr, fifo_wdata);
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_handshake();
        int ts, tg;
        logic [1:0] pids [4];
        pids[0] = 2'b01; pids[1] = 2'b00; pids[2] = 2'b10; pids[3] = 2'b11;
        busy_len = 10;
        for (int i = 0; i < 4; i++) begin
            run_packet(1'b0, pids[i], 0, 1'b0, ts, tg);
            n_checks++;
            if (ts !== 2) begin
                n_fail++;
                $display("FAIL hs_start_latency pid=%0d: got %0d required 2", pids[i], ts);
            end
            n_checks++;
            if (tg !== busy_len + 3) begin
                n_fail++;
                $display("FAIL hs_gnt_latency pid=%0d: got %0d required %0d", pids[i], tg, busy_len + 3);
            end
            @(posedge clk); #1;
            n_checks++;
            if (hs_gnt !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL hs_after_gnt: hs_gnt=%b busy=%b pending=%0d required 0 0 0",
                         hs_gnt, busy, exp_q.size());
            end
        end
    endtask

    task automatic test_data_toggle();
        int ts, tg;
        // order: first send, resend without ack, send after ack, resend without ack
        bit acks [4];
        acks[0] = 0; acks[1] = 0; acks[2] = 1; acks[3] = 0;
        buf_mem[0] = 8'hA0; buf_mem[1] = 8'hA1; buf_mem[2] = 8'hA2;
        busy_len = 4;
        for (int i = 0; i < 4; i++) begin
            if (acks[i]) pulse_ack();
            run_packet(1'b1, 2'b00, 3, 1'b0, ts, tg);
            n_checks++;
            if (ts !== 8) begin
                n_fail++;
                $display("FAIL data_start_latency run=%0d: got %0d required 8", i, ts);
            end
            n_checks++;
            if (tg !== busy_len + 3) begin
                n_fail++;
                $display("FAIL data_gnt_latency run=%0d: got %0d required %0d", i, tg, busy_len + 3);
            end
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL data_bytes_left run=%0d: got %0d required 0", i, exp_q.size());
            end
            @(posedge clk); #1;
        end
        // An ACK during the PID write must send the old toggle; the next packet sees the new one.
        run_packet(1'b1, 2'b00, 1, 1'b1, ts, tg);
        @(posedge clk); #1;
        run_packet(1'b1, 2'b00, 1, 1'b0, ts, tg);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ack_in_pid_left: got %0d required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        int  n;
        bit  hs_first;
        bit  got_data;
        int  d0;
        busy_len = 3;
        d0 = data_gnt_cnt;
        push_expect(1'b0, 2'b01, 0);
        push_expect(1'b1, 2'b00, 2);
        hs_pid = 2'b01; data_len = 7'd2;
        hs_req = 1'b1; data_req = 1'b1;
        hs_first = 1'b0; got_data = 1'b0;
        n = 0;
        while (n < 500) begin
            @(posedge clk); #1;
            n++;
            if (hs_gnt || data_gnt) begin
                hs_first = hs_gnt && !data_gnt;
                break;
            end
        end
        hs_req = 1'b0;
        n_checks++;
        if (hs_first !== 1'b1 || data_gnt_cnt != d0) begin
            n_fail++;
            $display("FAIL priority_first: hs_first=%b data_gnts=%0d required 1 %0d",
                     hs_first, data_gnt_cnt - d0, 0);
        end
        n = 0;
        while (n < 500) begin
            @(posedge clk); #1;
            n++;
            if (data_gnt) begin
                got_data = 1'b1;
                break;
            end
        end
        data_req = 1'b0;
        n_checks++;
        if (got_data !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL priority_second: data_gnt=%b pending=%0d required 1 0", got_data, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fifo_stall();
        int ts, tg, w0, guard;
        logic [LEN_W-1:0] ra;
        for (int i = 0; i < 128; i++) buf_mem[i] = 8'(i * 37 + 11);
        busy_len = 2;
        w0 = wr_count;
        fork
            run_packet(1'b1, 2'b00, 8, 1'b0, ts, tg);
            begin
                guard = 0;
                while (wr_count < w0 + 4 && guard < 200) begin
                    @(posedge clk); #1;
                    guard++;
                end
                fifo_full = 1'b1;
                ra = buf_raddr;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (fifo_wen !== 1'b0 || buf_raddr !== ra) begin
                        n_fail++;
                        $display("FAIL stall_frozen cyc=%0d: wen=%b raddr=%0d required 0 %0d",
                                 k, fifo_wen, buf_raddr, ra);
                    end
                end
                @(posedge clk); #1;
                fifo_full = 1'b0;
            end
        join
        n_checks++;
        if (exp_q.size() != 0 || wr_count - w0 != 9) begin
            n_fail++;
            $display("FAIL stall_sequence: pending=%0d writes=%0d required 0 9",
                     exp_q.size(), wr_count - w0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_bounds();
        int ts, tg, w0;
        busy_len = 1;
        w0 = wr_count;
        run_packet(1'b1, 2'b00, 0, 1'b0, ts, tg);
        n_checks++;
        if (ts !== 2 || wr_count - w0 != 1) begin
            n_fail++;
            $display("FAIL len0: t_start=%0d writes=%0d required 2 1", ts, wr_count - w0);
        end
        @(posedge clk); #1;
        w0 = wr_count;
        run_packet(1'b1, 2'b00, 100, 1'b0, ts, tg);
        n_checks++;
        if (ts !== 2 + 2 * MAX_LEN || wr_count - w0 != MAX_LEN + 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len_clamp: t_start=%0d writes=%0d pending=%0d required %0d %0d 0",
                     ts, wr_count - w0, exp_q.size(), 2 + 2 * MAX_LEN, MAX_LEN + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ts, tg, w0, guard, h0, d0;
        busy_len = 2;
        if (!tog) pulse_ack();
        w0 = wr_count;
        push_expect(1'b1, 2'b00, 10);
        data_len = 7'd10;
        data_req = 1'b1;
        guard = 0;
        while (wr_count < w0 + 4 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({hs_gnt, data_gnt, fifo_wen, tx_start, busy, timeout_err} !== 6'b0 ||
            buf_raddr !== '0 || fifo_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: strobes=%b raddr=%0d wdata=%h required 0",
                     {hs_gnt, data_gnt, fifo_wen, tx_start, busy, timeout_err}, buf_raddr, fifo_wdata);
        end
        exp_q.delete();
        data_req = 1'b0;
        tog = 1'b0;
        h0 = hs_gnt_cnt; d0 = data_gnt_cnt;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (hs_gnt_cnt != h0 || data_gnt_cnt != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_grant: gnts=%0d busy=%b required 0 0",
                     hs_gnt_cnt - h0 + data_gnt_cnt - d0, busy);
        end
        run_packet(1'b1, 2'b00, 2, 1'b0, ts, tg);
        n_checks++;
        if (exp_q.size() != 0 || ts !== 6) begin
            n_fail++;
            $display("FAIL reset_toggle_data0: pending=%0d t_start=%0d required 0 6", exp_q.size(), ts);
        end
        @(posedge clk); #1;
    endtask

`ifdef USB_TX_TIMEOUT_EN
    task automatic test_timeout();
        int n, k;
        busy_len = 0;
        push_expect(1'b0, 2'b00, 0);
        hs_pid = 2'b00;
        hs_req = 1'b1;
        n = 0;
        while (n < 100 && tx_start !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        k = -1;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(posedge clk); #1;
            if (timeout_err === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k !== TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d required %0d", k, TIMEOUT);
        end
        @(posedge clk); #1;
        n_checks++;
        if (hs_gnt !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_grant: hs_gnt=%b timeout_err=%b required 1 0", hs_gnt, timeout_err);
        end
        hs_req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: busy=%b required 0", busy);
        end
    endtask
`else
    task automatic test_timeout();
        // Without the watchdog, timeout_err must never pulse. The monitor ran through all earlier traffic.
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_tied: got %b required 0", timeout_err);
        end
    endtask
`endif

    always @(negedge clk) begin
        if (n_rst && timeout_err === 1'b1 && busy_len != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_timeout: timeout_err=1 required 0");
        end
    end

    initial begin
        test_reset();
        test_handshake();
        test_data_toggle();
        test_priority();
        test_fifo_stall();
        test_len_bounds();
        test_reset_mid();
        test_timeout();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
